// File: rtl/axi_lite_bram_ctrl.sv
// AXI4-Lite slave bridging single-beat reads and writes onto a block RAM port.
// Latency: write accepted in 1 cycle, bvalid next cycle; rvalid rises LATENCY+1 cycles after the AR handshake.
// Backpressure: one transaction in flight; no AW/W/AR handshake while bvalid or rvalid waits on bready/rready.
//
// Ports:
//   clk, reset                  - single clock, synchronous active-high reset
//   s_axi_aw*/w*/b*             - AXI4-Lite write address, data and response channels
//   s_axi_ar*/r*                - AXI4-Lite read address and data channels
//   bram_en/we/addr/wrdata      - RAM request, driven combinationally in the handshake cycle only
//   bram_rddata                 - RAM read data, valid LATENCY cycles after the enabled read
//
// Build option: define AXI_BRAM_ERR_RESP_EN to answer out-of-range word indices with SLVERR and
// no RAM access; otherwise addresses wrap modulo DEPTH and every response is OKAY.
module axi_lite_bram_ctrl #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16384,
  parameter int LATENCY    = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [ADDR_WIDTH-1:0]         s_axi_awaddr,
  input  logic                          s_axi_awvalid,
  output logic                          s_axi_awready,
  input  logic [DATA_WIDTH-1:0]         s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0]       s_axi_wstrb,
  input  logic                          s_axi_wvalid,
  output logic                          s_axi_wready,
  output logic [1:0]                    s_axi_bresp,
  output logic                          s_axi_bvalid,
  input  logic                          s_axi_bready,
  input  logic [ADDR_WIDTH-1:0]         s_axi_araddr,
  input  logic                          s_axi_arvalid,
  output logic                          s_axi_arready,
  output logic [DATA_WIDTH-1:0]         s_axi_rdata,
  output logic [1:0]                    s_axi_rresp,
  output logic                          s_axi_rvalid,
  input  logic                          s_axi_rready,
  output logic                          bram_en,
  output logic [DATA_WIDTH/8-1:0]       bram_we,
  output logic [$clog2(DEPTH)-1:0]      bram_addr,
  output logic [DATA_WIDTH-1:0]         bram_wrdata,
  input  logic [DATA_WIDTH-1:0]         bram_rddata
);

  localparam int OFFS = $clog2(DATA_WIDTH / 8);
  localparam int AW   = $clog2(DEPTH);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  // Wait counter runs 0..LATENCY: data is captured at LATENCY-1 (RAM output valid),
  // the response is presented one cycle later.
  localparam logic [1:0] CNT_CAP  = 2'(LATENCY - 1);
  localparam logic [1:0] CNT_LAST = 2'(LATENCY);

  typedef enum logic [1:0] {IDLE, WR_RESP, RD_WAIT, RD_RESP} state_t;

  state_t     state, state_nxt;
  logic       last_wr;      // 1 when the most recent grant went to a write
  logic [1:0] wait_cnt;
  logic       rd_err;
  logic       wr_req, rd_req;
  logic       wr_go, rd_go;
  logic       wr_oob, rd_oob;
  logic       unused_addr;

  assign wr_req = s_axi_awvalid & s_axi_wvalid;
  assign rd_req = s_axi_arvalid;

`ifdef AXI_BRAM_ERR_RESP_EN
  // Any address bit above the RAM word index means the word index is >= DEPTH.
  assign wr_oob = (s_axi_awaddr >> (OFFS + AW)) != '0;
  assign rd_oob = (s_axi_araddr >> (OFFS + AW)) != '0;
`else
  assign wr_oob = 1'b0;
  assign rd_oob = 1'b0;
`endif

  // Low byte-offset bits (and upper bits when wrapping) are intentionally dropped.
  assign unused_addr = ^{s_axi_awaddr, s_axi_araddr};

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    wr_go     = 1'b0;
    rd_go     = 1'b0;
    bram_en   = 1'b0;
    bram_we   = '0;
    bram_addr = s_axi_araddr[OFFS +: AW];
    unique case (state)
      IDLE: begin
        if (!reset) begin
          // Contention goes to whichever side was not served last.
          if (wr_req && (!rd_req || !last_wr)) begin
            wr_go     = 1'b1;
            state_nxt = WR_RESP;
          end else if (rd_req) begin
            rd_go     = 1'b1;
            state_nxt = RD_WAIT;
          end
        end
      end
      WR_RESP: if (s_axi_bready) state_nxt = IDLE;
      RD_WAIT: if (wait_cnt == CNT_LAST) state_nxt = RD_RESP;
      RD_RESP: if (s_axi_rready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (wr_go) begin
      bram_addr = s_axi_awaddr[OFFS +: AW];
      bram_en   = !wr_oob;
      bram_we   = wr_oob ? '0 : s_axi_wstrb;
    end else if (rd_go) begin
      bram_en   = !rd_oob;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_wr     <= 1'b0;
      wait_cnt    <= '0;
      rd_err      <= 1'b0;
      s_axi_rdata <= '0;
      s_axi_bresp <= RESP_OKAY;
      s_axi_rresp <= RESP_OKAY;
    end else begin
      if (wr_go) begin
        last_wr     <= 1'b1;
        s_axi_bresp <= wr_oob ? RESP_SLVERR : RESP_OKAY;
      end
      if (rd_go) begin
        last_wr  <= 1'b0;
        rd_err   <= rd_oob;
        wait_cnt <= '0;
      end
      if (state == RD_WAIT) begin
        wait_cnt <= wait_cnt + 2'd1;
        if (wait_cnt == CNT_CAP) begin
          s_axi_rdata <= rd_err ? '0 : bram_rddata;
          s_axi_rresp <= rd_err ? RESP_SLVERR : RESP_OKAY;
        end
      end
    end
  end

  assign s_axi_awready = wr_go;
  assign s_axi_wready  = wr_go;
  assign s_axi_arready = rd_go;
  assign s_axi_bvalid  = (state == WR_RESP) && !reset;
  assign s_axi_rvalid  = (state == RD_RESP) && !reset;
  assign bram_wrdata   = s_axi_wdata;

endmodule

// File: tb/tb_axi_lite_bram_ctrl.sv
module tb_axi_lite_bram_ctrl;

  localparam int DEPTH = 16384;
  localparam int LAT   = 1;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] s_axi_awaddr, s_axi_wdata, s_axi_araddr, s_axi_rdata;
  logic        s_axi_awvalid, s_axi_awready, s_axi_wvalid, s_axi_wready;
  logic [3:0]  s_axi_wstrb;
  logic [1:0]  s_axi_bresp, s_axi_rresp;
  logic        s_axi_bvalid, s_axi_bready, s_axi_arvalid, s_axi_arready;
  logic        s_axi_rvalid, s_axi_rready;
  logic        bram_en;
  logic [3:0]  bram_we;
  logic [13:0] bram_addr;
  logic [31:0] bram_wrdata, bram_rddata;

  int n_checks = 0;
  int n_fail   = 0;
  int en_count = 0;
  int viol     = 0;

  logic [31:0] ref_mem [int];

  always #5 clk = ~clk;

  axi_lite_bram_ctrl #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(DEPTH), .LATENCY(LAT)) dut (
    .clk(clk), .reset(reset),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
    .s_axi_wready(s_axi_wready), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
    .s_axi_bready(s_axi_bready), .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid),
    .s_axi_arready(s_axi_arready), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready), .bram_en(bram_en),
    .bram_we(bram_we), .bram_addr(bram_addr), .bram_wrdata(bram_wrdata), .bram_rddata(bram_rddata)
  );

  // Block RAM with LAT-cycle registered read; output holds between reads.
  logic [31:0] bram [0:DEPTH-1] = '{default: '0};
  logic [31:0] rd_pipe [0:2] = '{default: '0};
  always @(posedge clk) begin
    if (bram_en) begin
      for (int b = 0; b < 4; b++)
        if (bram_we[b]) bram[bram_addr][8*b +: 8] <= bram_wrdata[8*b +: 8];
      if (bram_we == 4'b0000) rd_pipe[0] <= bram[bram_addr];
    end
    rd_pipe[1] <= rd_pipe[0];
    rd_pipe[2] <= rd_pipe[1];
  end
  assign bram_rddata = rd_pipe[LAT-1];

  // Protocol watcher: RAM access only in a handshake cycle, paired AW/W ready, quiet in reset.
  always @(negedge clk) begin
    if (bram_en) en_count <= en_count + 1;
    if ((bram_en && !((s_axi_awvalid && s_axi_awready && s_axi_wvalid && s_axi_wready) ||
                      (s_axi_arvalid && s_axi_arready))) ||
        (s_axi_awready != s_axi_wready) ||
        (bram_en && s_axi_arready && bram_we != 4'b0000) ||
        (reset && (s_axi_awready || s_axi_arready || bram_en || s_axi_bvalid || s_axi_rvalid)))
      viol <= viol + 1;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit is_err(input logic [31:0] addr);
`ifdef AXI_BRAM_ERR_RESP_EN
    return (addr >> 2) >= DEPTH;
`else
    return 1'b0;
`endif
  endfunction

  function automatic int widx(input logic [31:0] addr);
    return int'((addr >> 2) % DEPTH);
  endfunction

  function automatic logic [31:0] exp_rdata(input logic [31:0] addr);
    if (is_err(addr)) return 32'h0;
    if (ref_mem.exists(widx(addr))) return ref_mem[widx(addr)];
    return 32'h0;
  endfunction

  task automatic model_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
    logic [31:0] w;
    if (!is_err(addr)) begin
      w = exp_rdata(addr);
      for (int b = 0; b < 4; b++)
        if (strb[b]) w[8*b +: 8] = data[8*b +: 8];
      ref_mem[widx(addr)] = w;
    end
  endtask

  // ---------------- bus drivers (entered and left at posedge+#1) ----------------
  task automatic issue_write(input string tag, input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb);
    bit hs = 0;
    s_axi_awaddr = addr; s_axi_wdata = data; s_axi_wstrb = strb;
    s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (s_axi_awready && s_axi_wready) begin hs = 1; break; end
      @(posedge clk); #1;
    end
    chk({tag, "_aw_handshake"}, 32'(hs), 32'd1);
    @(posedge clk); #1;
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
  endtask

  task automatic finish_write(input string tag, input logic [31:0] addr, input logic [31:0] data,
                              input logic [3:0] strb);
    int n = 0;
    while (!s_axi_bvalid && n < 40) begin @(posedge clk); #1; n++; end
    chk({tag, "_bvalid"}, 32'(s_axi_bvalid), 32'd1);
    chk({tag, "_bresp"}, 32'(s_axi_bresp), is_err(addr) ? 32'd2 : 32'd0);
    model_write(addr, data, strb);
    @(posedge clk); #1;
    chk({tag, "_bvalid_drop"}, 32'(s_axi_bvalid), 32'd0);
  endtask

  task automatic issue_read(input string tag, input logic [31:0] addr);
    bit hs = 0;
    s_axi_araddr = addr; s_axi_arvalid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (s_axi_arready) begin hs = 1; break; end
      @(posedge clk); #1;
    end
    chk({tag, "_ar_handshake"}, 32'(hs), 32'd1);
    @(posedge clk); #1;
    s_axi_arvalid = 1'b0;
  endtask

  task automatic finish_read(input string tag, input logic [31:0] addr);
    logic [31:0] ed;
    int n = 0;
    int hold;
    ed = exp_rdata(addr);
    while (!s_axi_rvalid && n < 40) begin @(posedge clk); #1; n++; end
    chk({tag, "_rvalid_latency"}, 32'(n), 32'(LAT + 1));
    chk({tag, "_rdata"}, s_axi_rdata, ed);
    chk({tag, "_rresp"}, 32'(s_axi_rresp), is_err(addr) ? 32'd2 : 32'd0);
    hold = $urandom_range(0, 2);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk({tag, "_rvalid_held"}, 32'(s_axi_rvalid), 32'd1);
      chk({tag, "_rdata_held"}, s_axi_rdata, ed);
    end
    s_axi_rready = 1'b1;
    @(posedge clk); #1;
    s_axi_rready = 1'b0;
    chk({tag, "_rvalid_drop"}, 32'(s_axi_rvalid), 32'd0);
  endtask

  task automatic do_write(input string tag, input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb);
    issue_write(tag, addr, data, strb);
    finish_write(tag, addr, data, strb);
  endtask

  task automatic do_read(input string tag, input logic [31:0] addr);
    issue_read(tag, addr);
    finish_read(tag, addr);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [31:0] a;
    logic [1:0]  grant_exp [3];
    int          en0;

    reset = 1'b1;
    s_axi_awaddr = '0; s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_araddr = '0;
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; s_axi_arvalid = 1'b0;
    s_axi_bready = 1'b1; s_axi_rready = 1'b0;

    // Reset state, including requests presented while reset is high.
    repeat (3) @(posedge clk);
    #1;
    s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1; s_axi_arvalid = 1'b1;
    #1;
    chk("rst_awready", 32'(s_axi_awready), 32'd0);
    chk("rst_arready", 32'(s_axi_arready), 32'd0);
    chk("rst_bram_en", 32'(bram_en), 32'd0);
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; s_axi_arvalid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    chk("rst_bvalid", 32'(s_axi_bvalid), 32'd0);
    chk("rst_rvalid", 32'(s_axi_rvalid), 32'd0);
    chk("rst_bresp", 32'(s_axi_bresp), 32'd0);
    chk("rst_rresp", 32'(s_axi_rresp), 32'd0);
    chk("rst_rdata", s_axi_rdata, 32'd0);

    // Simultaneous write and read requests: write first after reset, then alternate.
    grant_exp[0] = 2'b10; grant_exp[1] = 2'b01; grant_exp[2] = 2'b10;
    for (int r = 0; r < 3; r++) begin
      s_axi_awaddr = 32'h40 + 32'(8 * r); s_axi_wdata = 32'h1111_0000 + 32'(r);
      s_axi_wstrb = 4'hF; s_axi_araddr = 32'h44;
      s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1; s_axi_arvalid = 1'b1;
      #1;
      chk("rr_grant", 32'({s_axi_awready, s_axi_arready}), 32'(grant_exp[r]));
      @(posedge clk); #1;
      s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; s_axi_arvalid = 1'b0;
      if (grant_exp[r] == 2'b10) finish_write("rr_wr", s_axi_awaddr, s_axi_wdata, 4'hF);
      else                       finish_read("rr_rd", 32'h44);
    end

    // Full-word write then read back.
    do_write("dead_wr", 32'h10, 32'hDEAD_BEEF, 4'hF);
    do_read("dead_rd", 32'h10);

    // Single-byte strobe over an all-ones word.
    do_write("strb_fill", 32'h20, 32'hFFFF_FFFF, 4'hF);
    do_write("strb_byte", 32'h20, 32'h0000_00AA, 4'h1);
    do_read("strb_rd", 32'h20);
    do_read("unaligned_rd", 32'h23);

    // Write response held by bready=0 blocks any new handshake and RAM access.
    s_axi_bready = 1'b0;
    issue_write("bp_wr", 32'h30, 32'h1234_5678, 4'hF);
    s_axi_awaddr = 32'h34; s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
    s_axi_araddr = 32'h34; s_axi_arvalid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_bvalid", 32'(s_axi_bvalid), 32'd1);
      chk("bp_awready", 32'(s_axi_awready), 32'd0);
      chk("bp_arready", 32'(s_axi_arready), 32'd0);
      chk("bp_bram_en", 32'(bram_en), 32'd0);
      @(posedge clk); #1;
    end
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; s_axi_arvalid = 1'b0;
    s_axi_bready = 1'b1;
    finish_write("bp_wr", 32'h30, 32'h1234_5678, 4'hF);
    do_read("bp_rd", 32'h30);

    // Word index beyond DEPTH: SLVERR with no RAM access, or wrap onto word 0.
    do_write("w0_wr", 32'h0, 32'h0BAD_F00D, 4'hF);
    en0 = en_count;
    do_read("oob_rd", 32'h1_0000);
`ifdef AXI_BRAM_ERR_RESP_EN
    chk("oob_rd_bram_en", 32'(en_count - en0), 32'd0);
`else
    chk("oob_rd_bram_en", 32'(en_count - en0), 32'd1);
`endif
    en0 = en_count;
    do_write("oob_wr", 32'h1_0004, 32'hCAFE_0001, 4'hF);
`ifdef AXI_BRAM_ERR_RESP_EN
    chk("oob_wr_bram_en", 32'(en_count - en0), 32'd0);
`else
    chk("oob_wr_bram_en", 32'(en_count - en0), 32'd1);
`endif
    do_read("oob_alias_rd", 32'h4);

    // Randomized traffic over 16 words and their out-of-range aliases.
    for (int i = 0; i < 60; i++) begin
      a = 32'($urandom_range(0, 15)) * 32'd4 + 32'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) a = a + 32'h1_0000;
      if ($urandom_range(0, 1) == 1) do_write("rnd_wr", a, $urandom, 4'($urandom_range(0, 15)));
      else                           do_read("rnd_rd", a);
    end
    for (int w = 0; w < 16; w++) do_read("sweep_rd", 32'(w * 4));

    // Reset during the read wait: response discarded, next read normal.
    issue_read("rst_mid", 32'h10);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("rst_mid_rvalid", 32'(s_axi_rvalid), 32'd0);
    chk("rst_mid_rdata", s_axi_rdata, 32'd0);
    for (int i = 0; i < LAT + 2; i++) begin
      @(posedge clk); #1;
      chk("rst_mid_quiet", 32'(s_axi_rvalid), 32'd0);
    end
    do_read("post_rst_rd", 32'h10);

    chk("protocol_monitor", 32'(viol), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_lite_bram_ctrl.md
AXI_LITE_BRAM_CTRL -- requirements
Module: axi_lite_bram_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, AXI byte-address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, data width; legal values 32 or 64.
REQ-003 SHALL have parameter DEPTH, default 16384, RAM word count, power of two.
REQ-004 SHALL have parameter LATENCY, default 1, RAM read latency in cycles; legal values 1 to 3.
REQ-005 SHALL have port clk  in  1  clock; one clock domain; reset synchronous, active-high.
REQ-006 SHALL have port reset  in  1  synchronous active-high reset.
REQ-007 SHALL have port s_axi_awaddr  in  ADDR_WIDTH  write address.
REQ-008 SHALL have port s_axi_awvalid/s_axi_awready  in/out  1  AW handshake.
REQ-009 SHALL have port s_axi_wdata  in  DATA_WIDTH  write data.
REQ-010 SHALL have port s_axi_wstrb  in  DATA_WIDTH/8  byte strobes.
REQ-011 SHALL have port s_axi_wvalid/s_axi_wready  in/out  1  W handshake.
REQ-012 SHALL have port s_axi_bresp  out  2  write response.
REQ-013 SHALL have port s_axi_bvalid/s_axi_bready  out/in  1  B handshake.
REQ-014 SHALL have port s_axi_araddr  in  ADDR_WIDTH  read address.
REQ-015 SHALL have port s_axi_arvalid/s_axi_arready  in/out  1  AR handshake.
REQ-016 SHALL have port s_axi_rdata  out  DATA_WIDTH  read data.
REQ-017 SHALL have port s_axi_rresp  out  2  read response.
REQ-018 SHALL have port s_axi_rvalid/s_axi_rready  out/in  1  R handshake.
REQ-019 SHALL have port bram_en  out  1  RAM enable.
REQ-020 SHALL have port bram_we  out  DATA_WIDTH/8  RAM byte write enables.
REQ-021 SHALL have port bram_addr  out  clog2(DEPTH)  RAM word address = axaddr[OFFS+:clog2(DEPTH)], OFFS = clog2(DATA_WIDTH/8).
REQ-022 SHALL have port bram_wrdata/bram_rddata  out/in  DATA_WIDTH  RAM write/read data.

Function
REQ-023 SHALL use FSM states IDLE, WR_RESP, RD_WAIT, RD_RESP; one outstanding transaction.
REQ-024 In IDLE, write request = awvalid AND wvalid; read request = arvalid; awready/wready asserted only together.
REQ-025 When write and read requests coincide in IDLE, the controller SHALL grant round-robin: last-served write means read wins, and vice versa; after reset, write wins.
REQ-026 On the write handshake cycle: bram_en=1, bram_we=wstrb, bram_addr/bram_wrdata driven combinationally; next state WR_RESP.
REQ-027 WR_RESP: bvalid=1, bresp=OKAY, held until bready; then IDLE; no new handshake while bvalid=1.
REQ-028 On the read handshake cycle: bram_en=1, bram_we=0; RD_WAIT counts LATENCY cycles; bram_rddata captured into rdata register at the end.
REQ-029 rvalid SHALL rise exactly LATENCY+1 cycles after the AR handshake edge; rdata/rresp stable until rready; then IDLE.
REQ-030 bram_en=0 and bram_we=0 in every cycle other than a handshake cycle.
REQ-031 Address bits below OFFS SHALL be ignored (unaligned accesses aligned down).

Reset
REQ-032 Reset (any state, including mid-transaction) SHALL force IDLE, all ready/valid outputs 0, bresp=rresp=00, rdata=0, round-robin pointer to write-first; an in-flight RAM read is discarded.

Configuration
REQ-033 With macro AXI_BRAM_ERR_RESP_EN defined, a word index (axaddr>>OFFS) >= DEPTH SHALL return SLVERR (10), suppress bram_en for that access, and return rdata=0; without it, the address SHALL wrap modulo DEPTH and the response SHALL always be OKAY.

Verification
REQ-034 Write 0xDEADBEEF, strb 1111, addr 0x10; read addr 0x10 -> rdata 0xDEADBEEF, rresp 00, rvalid at handshake+LATENCY+1.
REQ-035 Write 0x000000AA strb 0001 over 0xFFFFFFFF at 0x20; read -> 0xFFFFFFAA.
REQ-036 AW+W and AR valid simultaneously for three consecutive requests after reset -> order write, read, write.
REQ-037 bready held 0 for 5 cycles -> bvalid stays 1, awready stays 0, no bram_en.
REQ-038 With DEPTH=16384 and the macro defined: read addr 0x10000 -> rresp 10, rdata 0, bram_en never 1; without the macro -> reads word 0, rresp 00.
REQ-039 Reset asserted during RD_WAIT -> next cycle rvalid=0, state IDLE, subsequent read completes normally.
